// File: rtl/mbscore_ifetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
interface mbscore_ifetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ibus_req;
  logic [ADDR_WIDTH-1:0] ibus_addr;
  logic                  ibus_ack;
  logic [DATA_WIDTH-1:0] ibus_rdata;
  logic                  ibus_err;

  modport master (
    output ibus_req, ibus_addr,
    input  ibus_ack, ibus_rdata, ibus_err
  );

  modport slave (
    input  ibus_req, ibus_addr,
    output ibus_ack, ibus_rdata, ibus_err
  );
endinterface

// File: rtl/mbscore_ifetch.sv
// MBS core instruction fetch: PC ownership, single outstanding ibus read,
// instruction register, and timeout / bus-error / misalignment detection.
module mbscore_ifetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_re,
  input  logic                  stop,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  mbscore_ifetch_if.master      ibus,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  pause,
  output logic                  fetch_err,
  output logic [1:0]            err_code
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
  localparam logic [1:0] ERR_BUS       = 2'd2;
  localparam logic [1:0] ERR_MISALIGN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic                  fetch_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; stop aborts everything except a PC redirect
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fetch_done = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = ERR_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (inst_re) begin
            if (pc_q[1:0] == 2'b00) begin
              state_d = ST_REQ;
              addr_d  = pc_q;
              cnt_d   = '0;
            end else begin
              state_d = ST_ERR;
              err_d   = ERR_MISALIGN;
            end
          end
        end
        ST_REQ: begin
          if (ibus.ibus_err) begin
            state_d = ST_ERR;
            err_d   = ERR_BUS;
          end else if (ibus.ibus_ack) begin
            state_d    = ST_IDLE;
            inst_d     = ibus.ibus_rdata;
            fetch_done = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_ERR;
            err_d   = ERR_TIMEOUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Redirect wins over the sequential advance
    if (pc_load) begin
      pc_d = pc_next;
    end else if (fetch_done) begin
      pc_d = addr_q + ADDR_WIDTH'(4);
    end
  end

  assign ibus.ibus_req  = (state_q == ST_REQ);
  assign ibus.ibus_addr = addr_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + ADDR_WIDTH'(4);
  assign pause          = (state_q == ST_REQ) || (state_q == ST_ERR);
  assign fetch_err      = (state_q == ST_ERR);
  assign err_code       = err_q;

endmodule

// File: tb/tb_mbscore_ifetch.sv
// Directed bench for mbscore_ifetch with TIMEOUT=4.
module tb_mbscore_ifetch;

  logic        clk;
  logic        rst_n;
  logic        inst_re;
  logic        stop;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pause;
  logic        fetch_err;
  logic [1:0]  err_code;

  int checks;
  int failures;

  mbscore_ifetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ibus ();

  mbscore_ifetch #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .TIMEOUT   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inst_re  (inst_re),
    .stop     (stop),
    .pc_load  (pc_load),
    .pc_next  (pc_next),
    .ibus     (ibus),
    .inst     (inst),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .pause    (pause),
    .fetch_err(fetch_err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs settle and inputs may be changed 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_req"}, 32'(ibus.ibus_req), 32'd0);
    check_eq({tag, "_pause"}, 32'(pause), 32'd0);
    check_eq({tag, "_ferr"}, 32'(fetch_err), 32'd0);
    check_eq({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    inst_re  = 1'b0;
    stop     = 1'b0;
    pc_load  = 1'b0;
    pc_next  = '0;
    ibus.ibus_ack   = 1'b0;
    ibus.ibus_rdata = '0;
    ibus.ibus_err   = 1'b0;

    step();
    step();
    rst_n = 1'b1;
    check_idle("rst");
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_addr", ibus.ibus_addr, 32'h0);
    check_eq("rst_pc4", pc_plus4, 32'h4);

    // Ack in the first REQ cycle
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    check_eq("t1_req", 32'(ibus.ibus_req), 32'd1);
    check_eq("t1_addr", ibus.ibus_addr, 32'h0);
    check_eq("t1_pause", 32'(pause), 32'd1);
    ibus.ibus_ack = 1'b1; ibus.ibus_rdata = 32'h2008_0005;
    step();
    ibus.ibus_ack = 1'b0;
    check_idle("t1_done");
    check_eq("t1_inst", inst, 32'h2008_0005);
    check_eq("t1_pc", pc, 32'h4);

    // Ack delayed three cycles, landing on the last cycle before timeout
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_req", 32'(ibus.ibus_req), 32'd1);
      check_eq("t2_addr", ibus.ibus_addr, 32'h4);
      check_eq("t2_pause", 32'(pause), 32'd1);
      check_eq("t2_pc_hold", pc, 32'h4);
      step();
    end
    check_eq("t2_req4", 32'(ibus.ibus_req), 32'd1);
    check_eq("t2_addr4", ibus.ibus_addr, 32'h4);
    ibus.ibus_ack = 1'b1; ibus.ibus_rdata = 32'h1111_2222;
    step();
    ibus.ibus_ack = 1'b0;
    check_idle("t2_done");
    check_eq("t2_inst", inst, 32'h1111_2222);
    check_eq("t2_pc", pc, 32'h8);

    // Redirect coinciding with ack
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    check_eq("t3_addr", ibus.ibus_addr, 32'h8);
    ibus.ibus_ack = 1'b1; ibus.ibus_rdata = 32'h3333_4444;
    pc_load = 1'b1; pc_next = 32'h40;
    step();
    ibus.ibus_ack = 1'b0; pc_load = 1'b0;
    check_eq("t3_pc", pc, 32'h40);
    check_eq("t3_inst", inst, 32'h3333_4444);
    check_eq("t3_req", 32'(ibus.ibus_req), 32'd0);

    // Timeout after four REQ cycles
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_req", 32'(ibus.ibus_req), 32'd1);
      check_eq("t4_ferr", 32'(fetch_err), 32'd0);
      step();
    end
    check_eq("t4_req_err", 32'(ibus.ibus_req), 32'd0);
    check_eq("t4_pause", 32'(pause), 32'd1);
    check_eq("t4_ferr_set", 32'(fetch_err), 32'd1);
    check_eq("t4_code", 32'(err_code), 32'd1);
    ibus.ibus_ack = 1'b1; ibus.ibus_rdata = 32'hDEAD_BEEF;
    step();
    ibus.ibus_ack = 1'b0;
    check_eq("t4_sticky", 32'(err_code), 32'd1);
    check_eq("t4_inst_keep", inst, 32'h3333_4444);
    check_eq("t4_pc_keep", pc, 32'h40);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("t4_stop");

    // Misaligned PC: no request, straight to ERR
    pc_load = 1'b1; pc_next = 32'h42;
    step();
    pc_load = 1'b0;
    check_eq("t5_pc", pc, 32'h42);
    check_eq("t5_pc4", pc_plus4, 32'h46);
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    check_eq("t5_req", 32'(ibus.ibus_req), 32'd0);
    check_eq("t5_pause", 32'(pause), 32'd1);
    check_eq("t5_code", 32'(err_code), 32'd3);
    check_eq("t5_ferr", 32'(fetch_err), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("t5_stop");

    // Bus error in REQ
    pc_load = 1'b1; pc_next = 32'h100;
    step();
    pc_load = 1'b0;
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    check_eq("t6_addr", ibus.ibus_addr, 32'h100);
    ibus.ibus_err = 1'b1; ibus.ibus_ack = 1'b1; ibus.ibus_rdata = 32'h5555_6666;
    step();
    ibus.ibus_err = 1'b0; ibus.ibus_ack = 1'b0;
    check_eq("t6_code", 32'(err_code), 32'd2);
    check_eq("t6_inst", inst, 32'h3333_4444);
    check_eq("t6_pc", pc, 32'h100);
    check_eq("t6_req", 32'(ibus.ibus_req), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("t6_stop");

    // Reset in mid-REQ, then a late ack
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    check_eq("t7_req", 32'(ibus.ibus_req), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle("t7_rst");
    check_eq("t7_pc", pc, 32'h0);
    check_eq("t7_inst", inst, 32'h0);
    check_eq("t7_addr", ibus.ibus_addr, 32'h0);
    ibus.ibus_ack = 1'b1; ibus.ibus_rdata = 32'h7777_8888;
    step();
    ibus.ibus_ack = 1'b0;
    check_eq("t7_late_inst", inst, 32'h0);
    check_eq("t7_late_pc", pc, 32'h0);

    // Stop coinciding with ack discards the data
    inst_re = 1'b1;
    step();
    inst_re = 1'b0;
    ibus.ibus_ack = 1'b1; ibus.ibus_rdata = 32'h9999_AAAA; stop = 1'b1;
    step();
    ibus.ibus_ack = 1'b0; stop = 1'b0;
    check_eq("t8_inst", inst, 32'h0);
    check_eq("t8_pc", pc, 32'h0);
    check_eq("t8_req", 32'(ibus.ibus_req), 32'd0);

    // pc_plus4 wraps
    pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
    step();
    pc_load = 1'b0;
    check_eq("t9_wrap", pc_plus4, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
